// File: rtl/covox_fifo_dac_if.sv
// Covox FIFO DAC bus: CPU-side write strobe, data, mixer bits and status/DAC outputs.
// master = decoder/CPU side, slave = covox_fifo_dac.
interface covox_fifo_dac_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_stb;
    logic [7:0]            wr_data;
    logic                  beeper;
    logic                  tape_out;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ovf;
    logic                  dac;

    modport master (
        output wr_stb, wr_data, beeper, tape_out,
        input  fifo_level, fifo_full, fifo_empty, ovf, dac
    );

    modport slave (
        input  wr_stb, wr_data, beeper, tape_out,
        output fifo_level, fifo_full, fifo_empty, ovf, dac
    );
endinterface

// File: rtl/covox_fifo_dac.sv
// Buffered Covox playback: port #FB writes are queued and released at a fixed
// sample rate, mixed with beeper/tape bits and sent to a 1-bit sigma-delta DAC.
// All logic runs on the falling edge of clk.
// Build option: define COVOX_FIFO_EN for the buffered FIFO path; without it the
// block runs in direct mode (sample updated straight from the write, no FIFO).
module covox_fifo_dac #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RATE_DIV   = 160
) (
    input  logic            clk,
    input  logic            rst,
    covox_fifo_dac_if.slave bus
);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6 || RATE_DIV < 2 || RATE_DIV > 65535) begin : g_param_check
        $error("covox_fifo_dac: DEPTH_LOG2 or RATE_DIV out of range");
    end

    logic       wr_q;
    logic       push;
    logic       push_q;
    logic [7:0] din_q;
    logic [7:0] sample;
    logic [8:0] mix;
    logic [7:0] mix_half;
    logic [8:0] acc;

    // One push per strobe assertion, however long the Z80 holds it.
    assign push = bus.wr_stb & ~wr_q;

    // Strobe edge detect and data capture on the rising-edge cycle.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            push_q <= 1'b0;
            din_q  <= 8'h00;
        end else begin
            wr_q   <= bus.wr_stb;
            push_q <= push;
            if (push) begin
                din_q <= bus.wr_data;
            end
        end
    end

`ifdef COVOX_FIFO_EN
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL  = DEPTH[DEPTH_LOG2:0];
    localparam logic [15:0]         RATE_LAST = 16'(RATE_DIV - 1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  full;
    logic                  empty;
    logic                  ovf_r;
    logic [15:0]           rate_cnt;
    logic                  tick;
    logic                  do_pop;
    logic                  do_push;

    assign tick    = (rate_cnt == RATE_LAST);
    assign do_pop  = tick & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_q & (~full | do_pop);

    // Next entry count from the push/pop pair.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Sample-rate divider, wraps at RATE_DIV-1.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rate_cnt <= 16'd0;
        end else if (tick) begin
            rate_cnt <= 16'd0;
        end else begin
            rate_cnt <= rate_cnt + 16'd1;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(negedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din_q;
        end
    end

    // Pointers, registered level/flags, sticky overflow and output sample.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf_r  <= 1'b0;
            sample <= 8'h00;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sample <= mem[rd_ptr];
            end
            if (push_q && full && !do_pop) begin
                ovf_r <= 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            empty <= (level_nxt == '0);
        end
    end

    assign bus.fifo_level = level;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.ovf        = ovf_r;
`else
    // Direct mode: the written byte becomes the sample one clk after capture.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sample <= 8'h00;
        end else if (push_q) begin
            sample <= din_q;
        end
    end

    assign bus.fifo_level = {(DEPTH_LOG2 + 1){1'b0}};
    assign bus.fifo_full  = 1'b0;
    assign bus.fifo_empty = 1'b1;
    assign bus.ovf        = 1'b0;
`endif

    // Beeper at weight 64, tape-out at weight 32, no saturation (max 351).
    assign mix      = {1'b0, sample} + {2'b00, bus.beeper, bus.tape_out, 5'b00000};
    assign mix_half = 8'(mix >> 1);

    // First-order sigma-delta: carry out of the 8-bit accumulator is the bitstream.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            acc <= 9'd0;
        end else begin
            acc <= {1'b0, acc[7:0]} + {1'b0, mix_half};
        end
    end

    assign bus.dac = acc[8];

endmodule
